// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: releases NUM_STAGES downstream reset domains in order,
// waiting a minimum gap and each stage's acknowledge before moving on.
// A missing acknowledge times out and restarts the whole sequence.
module reset_seq_ctrl #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned HOLD_CYCLES    = 200,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter bit          RST_LEVEL      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  all_ready,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [7:0]            retry_cnt
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    localparam logic [NUM_STAGES-1:0] ALL_ASSERTED = {NUM_STAGES{RST_LEVEL}};

    typedef enum logic [1:0] {
        ASSERT   = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    logic          sync_ff1;
    logic          rst_sync_n;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n, idx_inc;
    logic [NUM_STAGES-1:0] rel, rel_n;
    logic          timeout_err_n;
    logic [7:0]    retry_cnt_n;
    logic          timeout_hit;

    // Released-stage mask: a set bit means that stage's reset is deasserted.
    assign rel     = stage_rst ^ ALL_ASSERTED;
    assign idx_inc = idx + 1'b1;

    // Two-flop synchronizer: async assertion, synchronous deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            sync_ff1   <= 1'b1;
            rst_sync_n <= sync_ff1;
        end
    end

    // State register plus registered outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ASSERT;
            cnt         <= '0;
            idx         <= '0;
            stage_rst   <= ALL_ASSERTED;
            all_ready   <= 1'b0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            retry_cnt   <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            stage_rst   <= rel_n ^ ALL_ASSERTED;
            all_ready   <= (state_n == DONE);
            busy        <= (state_n != DONE);
            timeout_err <= timeout_err_n;
            retry_cnt   <= retry_cnt_n;
        end
    end

    // Next-state logic: hold, gap/ack advance, timeout retry, soft request override.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        idx_n         = idx;
        rel_n         = rel;
        timeout_err_n = timeout_err;
        retry_cnt_n   = retry_cnt;
        timeout_hit   = 1'b0;

        if (!rst_sync_n) begin
            state_n = ASSERT;
            cnt_n   = '0;
            idx_n   = '0;
            rel_n   = '0;
        end else begin
            case (state)
                ASSERT: begin
                    rel_n = '0;
                    if (cnt == HOLD_LAST) begin
                        state_n = WAIT_ACK;
                        idx_n   = '0;
                        cnt_n   = '0;
                        rel_n   = NUM_STAGES'(1);
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // Acknowledge is tested before timeout so a same-cycle ack wins.
                    if ((cnt >= GAP_LAST) && stage_ack[idx]) begin
                        cnt_n = '0;
                        if (idx == IDX_LAST) begin
                            state_n = DONE;
                        end else begin
                            idx_n        = idx_inc;
                            rel_n[idx_inc] = 1'b1;
                        end
                    end else if (cnt == TO_LAST) begin
                        timeout_hit = 1'b1;
                        state_n     = ASSERT;
                        cnt_n       = '0;
                        idx_n       = '0;
                        rel_n       = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DONE: begin
                    rel_n = '1;
                end
                default: begin
                    state_n = ASSERT;
                    cnt_n   = '0;
                    idx_n   = '0;
                    rel_n   = '0;
                end
            endcase

            if (timeout_hit) begin
                timeout_err_n = 1'b1;
                if (retry_cnt != 8'hFF) begin
                    retry_cnt_n = retry_cnt + 8'd1;
                end
            end

            // Soft request overrides the transition but keeps any timeout bookkeeping.
            if (soft_rst_req) begin
                state_n = ASSERT;
                cnt_n   = '0;
                idx_n   = '0;
                rel_n   = '0;
            end
        end
    end

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: 3 stages, hold 8, gap 4, timeout 32.
module tb_reset_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       soft_rst_req;
    logic [2:0] stage_ack;
    logic [2:0] stage_rst;
    logic       all_ready;
    logic       busy;
    logic       timeout_err;
    logic [7:0] retry_cnt;

    int errors;
    int checks;

    reset_seq_ctrl #(
        .NUM_STAGES    (3),
        .HOLD_CYCLES   (8),
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(32),
        .RST_LEVEL     (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .soft_rst_req(soft_rst_req),
        .stage_ack   (stage_ack),
        .stage_rst   (stage_rst),
        .all_ready   (all_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .retry_cnt   (retry_cnt)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        soft_rst_req = 1'b0;
        stage_ack    = 3'b111;

        // Reset values
        step(3);
        chk("rst_stage_rst", 32'(stage_rst), 32'h0);
        chk("rst_all_ready", 32'(all_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_retry_cnt", 32'(retry_cnt), 32'h0);

        // Nominal sequence with acks tied high; edge 0 is 2 edges after release
        rst_n = 1'b1;
        step(2);
        chk("e0_stage_rst", 32'(stage_rst), 32'h0);
        step(7);
        chk("e7_stage_rst", 32'(stage_rst), 32'h0);
        step(1);
        chk("e8_stage_rst", 32'(stage_rst), 32'h1);
        chk("e8_busy", 32'(busy), 32'h1);
        step(3);
        chk("e11_stage_rst", 32'(stage_rst), 32'h1);
        step(1);
        chk("e12_stage_rst", 32'(stage_rst), 32'h3);
        step(4);
        chk("e16_stage_rst", 32'(stage_rst), 32'h7);
        chk("e16_all_ready", 32'(all_ready), 32'h0);
        step(3);
        chk("e19_all_ready", 32'(all_ready), 32'h0);
        chk("e19_busy", 32'(busy), 32'h1);
        step(1);
        chk("e20_all_ready", 32'(all_ready), 32'h1);
        chk("e20_busy", 32'(busy), 32'h0);

        // Acks ignored in DONE
        stage_ack = 3'b000;
        step(3);
        chk("done_ack_ignored_ready", 32'(all_ready), 32'h1);
        chk("done_ack_ignored_rst", 32'(stage_rst), 32'h7);

        // Soft request from DONE, then a late ack on stage 1
        stage_ack    = 3'b101;
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        chk("soft_stage_rst", 32'(stage_rst), 32'h0);
        chk("soft_all_ready", 32'(all_ready), 32'h0);
        chk("soft_busy", 32'(busy), 32'h1);
        chk("soft_retry_cnt", 32'(retry_cnt), 32'h0);
        step(7);
        chk("soft7_stage_rst", 32'(stage_rst), 32'h0);
        step(1);
        chk("soft8_stage_rst", 32'(stage_rst), 32'h1);
        step(4);
        chk("soft12_stage_rst", 32'(stage_rst), 32'h3);
        step(10);
        chk("late_ack_wait", 32'(stage_rst), 32'h3);
        stage_ack = 3'b111;
        step(1);
        chk("late_ack_release", 32'(stage_rst), 32'h7);
        chk("late_ack_no_timeout", 32'(timeout_err), 32'h0);
        step(4);
        chk("late_ack_all_ready", 32'(all_ready), 32'h1);

        // Stage 2 ack missing: timeout, retry, then ack arrives exactly at timeout cycle
        stage_ack    = 3'b011;
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        step(16);
        chk("to_stage2_released", 32'(stage_rst), 32'h7);
        step(31);
        chk("to_before_rst", 32'(stage_rst), 32'h7);
        chk("to_before_err", 32'(timeout_err), 32'h0);
        step(1);
        chk("to_stage_rst", 32'(stage_rst), 32'h0);
        chk("to_err", 32'(timeout_err), 32'h1);
        chk("to_retry_cnt", 32'(retry_cnt), 32'h1);
        chk("to_busy", 32'(busy), 32'h1);
        step(16);
        chk("retry_stage2_released", 32'(stage_rst), 32'h7);
        step(31);
        chk("retry_before_ack", 32'(all_ready), 32'h0);
        stage_ack = 3'b111;
        step(1);
        chk("ack_wins_all_ready", 32'(all_ready), 32'h1);
        chk("ack_wins_err_sticky", 32'(timeout_err), 32'h1);
        chk("ack_wins_retry_cnt", 32'(retry_cnt), 32'h1);

        // Async reset mid WAIT_ACK on stage 1
        stage_ack    = 3'b101;
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        step(14);
        chk("mid_stage_rst", 32'(stage_rst), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_stage_rst", 32'(stage_rst), 32'h0);
        chk("async_all_ready", 32'(all_ready), 32'h0);
        chk("async_busy", 32'(busy), 32'h1);
        chk("async_timeout_err", 32'(timeout_err), 32'h0);
        chk("async_retry_cnt", 32'(retry_cnt), 32'h0);

        // Repeated timeouts: one every 40 edges, counter saturates at 255
        stage_ack = 3'b000;
        step(1);
        rst_n = 1'b1;
        step(2);
        step(40);
        chk("sat_first_retry", 32'(retry_cnt), 32'h1);
        step(40 * 99);
        chk("sat_retry_100", 32'(retry_cnt), 32'd100);
        step(40 * 155 - 1);
        chk("sat_retry_254", 32'(retry_cnt), 32'd254);
        step(1);
        chk("sat_retry_255", 32'(retry_cnt), 32'd255);
        step(40 * 45);
        chk("sat_retry_300", 32'(retry_cnt), 32'd255);
        chk("sat_err", 32'(timeout_err), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
